fifo_wr_pckt_ctrl: RTL and testbench



---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_pckt_stats.sv | 44 ++++
 rtl/fifo_wr_pckt_ctrl.sv | 123 ++++++++++++
 tb/tb_fifo_wr_pckt_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types for the packet-aware FIFO write controller.
// Holds the controller state encoding and its width constant.
package fifo_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DROP  = 2'd2
  } state_t;

endpackage

// File: rtl/fifo_pckt_stats.sv
// Packet statistics for fifo_wr_pckt_ctrl: good/dropped packet counters
// (wrapping) and a sticky overflow flag cleared only by reset.
// Only built when FIFO_WR_CTRL_STATS_EN is defined.
// Ports:
//   clk, reset            write-domain clock, synchronous active-high reset
//   good_i, drop_i, ovf_i one-cycle event pulses from the controller
//   pckt_good_cnt_o       committed packet count
//   pckt_drop_cnt_o       dropped packet count
//   overflow_o            sticky: a packet was dropped because the FIFO was full
`ifdef FIFO_WR_CTRL_STATS_EN
module fifo_pckt_stats #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 good_i,
  input  logic                 drop_i,
  input  logic                 ovf_i,
  output logic [CNT_WIDTH-1:0] pckt_good_cnt_o,
  output logic [CNT_WIDTH-1:0] pckt_drop_cnt_o,
  output logic                 overflow_o
);

  logic [CNT_WIDTH-1:0] good_q, drop_q;
  logic                 ovf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      good_q <= '0;
      drop_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (good_i) good_q <= good_q + 1'b1;
      if (drop_i) drop_q <= drop_q + 1'b1;
      if (ovf_i)  ovf_q  <= 1'b1;
    end
  end

  assign pckt_good_cnt_o = good_q;
  assign pckt_drop_cnt_o = drop_q;
  assign overflow_o      = ovf_q;

endmodule
`endif

// File: rtl/fifo_wr_pckt_ctrl.sv
// Packet-aware write controller between the rx MAC AXI-Stream master and the
// async FIFO write-pointer stage. Good packets are committed (latch_addr with
// the last beat); bad or full-hit packets are rolled back (drop_pckt); packets
// starting while almost-full are discarded whole without writing.
// FIFO controls are combinational from state and the current beat.
// Optional: define FIFO_WR_CTRL_STATS_EN to build the statistics block;
// otherwise pckt_good_cnt, pckt_drop_cnt and overflow are tied to 0.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   s_axis_tdata/tvalid/tlast/tuser rx beat (no backpressure)
//   fifo_full, fifo_almost_full     flags from the write-pointer stage
//   fifo_write, fifo_wdata          write strobe and data
//   latch_addr, drop_pckt           commit / rollback pulses
//   pckt_good_cnt, pckt_drop_cnt    packet statistics
//   overflow                        sticky full-drop flag
module fifo_wr_pckt_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  input  logic                  fifo_full,
  input  logic                  fifo_almost_full,
  output logic                  fifo_write,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  output logic                  latch_addr,
  output logic                  drop_pckt,
  output logic [CNT_WIDTH-1:0]  pckt_good_cnt,
  output logic [CNT_WIDTH-1:0]  pckt_drop_cnt,
  output logic                  overflow
);

  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    fifo_write = 1'b0;
    latch_addr = 1'b0;
    drop_pckt  = 1'b0;
    if (s_axis_tvalid) begin
      unique case (state_q)
        IDLE: begin
          // Nothing written yet, so a rejected first beat needs no rollback.
          if (fifo_almost_full || s_axis_tuser || fifo_full) begin
            if (!s_axis_tlast) state_d = DROP;
          end else begin
            fifo_write = 1'b1;
            if (s_axis_tlast) latch_addr = 1'b1;
            else              state_d    = WRITE;
          end
        end
        WRITE: begin
          if (s_axis_tuser || fifo_full) begin
            drop_pckt = 1'b1;
            state_d   = s_axis_tlast ? IDLE : DROP;
          end else begin
            fifo_write = 1'b1;
            if (s_axis_tlast) begin
              latch_addr = 1'b1;
              state_d    = IDLE;
            end
          end
        end
        DROP: begin
          if (s_axis_tlast) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    // Outputs are held low while reset is asserted, even with a beat present.
    if (reset) begin
      fifo_write = 1'b0;
      latch_addr = 1'b0;
      drop_pckt  = 1'b0;
    end
  end

  assign fifo_wdata = s_axis_tdata;

`ifdef FIFO_WR_CTRL_STATS_EN
  logic idle_rej, good_p, drop_p, ovf_p;

  // Event pulses re-derived from the same priority as the FSM: a first-beat
  // rejection in IDLE counts as a drop even though drop_pckt stays low.
  always_comb begin
    idle_rej = (state_q == IDLE) && s_axis_tvalid &&
               (fifo_almost_full || s_axis_tuser || fifo_full);
    good_p   = latch_addr;
    drop_p   = drop_pckt || (idle_rej && !reset);
    ovf_p    = s_axis_tvalid && fifo_full && !s_axis_tuser && !reset &&
               (((state_q == IDLE) && !fifo_almost_full) || (state_q == WRITE));
  end

  fifo_pckt_stats #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_stats (
    .clk             (clk),
    .reset           (reset),
    .good_i          (good_p),
    .drop_i          (drop_p),
    .ovf_i           (ovf_p),
    .pckt_good_cnt_o (pckt_good_cnt),
    .pckt_drop_cnt_o (pckt_drop_cnt),
    .overflow_o      (overflow)
  );
`else
  assign pckt_good_cnt = '0;
  assign pckt_drop_cnt = '0;
  assign overflow      = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_pckt_ctrl.sv
// Bench for fifo_wr_pckt_ctrl with a behavioural 16-entry packet FIFO
// (almost-full at occupancy >= 15) driven by the DUT's controls.
module tb_fifo_wr_pckt_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid, s_axis_tlast, s_axis_tuser;
  logic          fifo_full, fifo_almost_full;
  logic          fifo_write, latch_addr, drop_pckt, overflow;
  logic [DW-1:0] fifo_wdata;
  logic [CW-1:0] pckt_good_cnt, pckt_drop_cnt;

  always #5 clk = ~clk;

  fifo_wr_pckt_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk              (clk),
    .reset            (reset),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tlast     (s_axis_tlast),
    .s_axis_tuser     (s_axis_tuser),
    .fifo_full        (fifo_full),
    .fifo_almost_full (fifo_almost_full),
    .fifo_write       (fifo_write),
    .fifo_wdata       (fifo_wdata),
    .latch_addr       (latch_addr),
    .drop_pckt        (drop_pckt),
    .pckt_good_cnt    (pckt_good_cnt),
    .pckt_drop_cnt    (pckt_drop_cnt),
    .overflow         (overflow)
  );

  // Write-pointer stage and reader model.
  logic [DW-1:0] mem [16];
  logic [4:0]    wp, cp, rp, occ;
  logic          rd_en;
  logic [DW-1:0] rd_data;

  assign occ              = wp - rp;
  assign fifo_full        = (occ == 5'd16);
  assign fifo_almost_full = (occ >= 5'd15);

  always @(posedge clk) begin
    if (reset) begin
      wp <= '0; cp <= '0; rp <= '0; rd_data <= '0;
    end else begin
      if (fifo_write && !fifo_full) begin
        mem[wp[3:0]] <= fifo_wdata;
        wp <= wp + 5'd1;
      end
      if (latch_addr) cp <= wp + ((fifo_write && !fifo_full) ? 5'd1 : 5'd0);
      if (drop_pckt)  wp <= cp;
      if (rd_en) begin
        if (rp != cp) begin
          rd_data <= mem[rp[3:0]];
          rp <= rp + 5'd1;
        end else begin
          rd_data <= 'x;
        end
      end
    end
  end

  int unsigned   errors = 0, checks = 0;
  int unsigned   exp_good = 0, exp_drop = 0;
  logic          exp_ovf = 1'b0;
  logic [DW-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stats(input string tag);
`ifdef FIFO_WR_CTRL_STATS_EN
    chk({tag, ".good"}, 32'(pckt_good_cnt), exp_good);
    chk({tag, ".drop"}, 32'(pckt_drop_cnt), exp_drop);
    chk({tag, ".ovf"},  32'(overflow), 32'(exp_ovf));
`else
    chk({tag, ".good"}, 32'(pckt_good_cnt), 0);
    chk({tag, ".drop"}, 32'(pckt_drop_cnt), 0);
    chk({tag, ".ovf"},  32'(overflow), 0);
`endif
  endtask

  // Drive one beat at posedge+1, check the combinational controls mid-cycle.
  task automatic beat(input string tag, input logic [DW-1:0] d, input logic last,
                      input logic user, input logic ew, input logic el, input logic ed);
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = last;
    s_axis_tuser  = user;
    #4;
    chk({tag, ".wr"},    32'(fifo_write), 32'(ew));
    chk({tag, ".latch"}, 32'(latch_addr), 32'(el));
    chk({tag, ".drop"},  32'(drop_pckt),  32'(ed));
    chk({tag, ".wrfull"}, 32'(fifo_write & fifo_full), 0);
    if (ew) chk({tag, ".wdata"}, 32'(fifo_wdata), 32'(d));
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic good_pkt(input string tag, input logic [DW-1:0] base, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      beat(tag, base + DW'(i), i == n - 1, 1'b0, 1'b1, i == n - 1, 1'b0);
      exp_q.push_back(base + DW'(i));
    end
    exp_good++;
  endtask

  task automatic drain(input string tag, input int unsigned n);
    logic [DW-1:0] e;
    for (int unsigned i = 0; i < n; i++) begin
      rd_en = 1'b1;
      @(posedge clk); #1;
      rd_en = 1'b0;
      chk({tag, ".sbnonempty"}, 32'(exp_q.size() != 0), 1);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      chk({tag, ".rdata"}, 32'(rd_data), 32'(e));
    end
  endtask

  initial begin
    reset = 1'b1; rd_en = 1'b0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #4;
    chk("rst.wr", 32'(fifo_write), 0);
    chk("rst.latch", 32'(latch_addr), 0);
    chk("rst.drop", 32'(drop_pckt), 0);
    chk_stats("rst");
    @(posedge clk); #1;

    // 5-beat good packet
    good_pkt("p5", 8'h01, 5);
    chk_stats("p5");
    drain("p5", 5);

    // tuser on beat 3 of a 4-beat packet, then a 2-beat good packet
    beat("bad.b1", 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    beat("bad.b2", 8'h12, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    beat("bad.b3", 8'h13, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    beat("bad.b4", 8'h14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_drop++;
    good_pkt("a0a1", 8'hA0, 2);
    chk_stats("bad");
    drain("a0a1", 2);
    chk("bad.occ", 32'(occ), 0);

    // single-beat bad packet in IDLE, then a single-beat good packet
    beat("sgl.bad", 8'h22, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_drop++;
    good_pkt("sgl.good", 8'h33, 1);
    chk_stats("sgl");
    drain("sgl", 1);

    // fill to 14, then a 6-beat packet hits full on beat 3
    for (int unsigned k = 0; k < 7; k++) good_pkt("fill14", 8'h40 + 8'(2 * k), 2);
    chk("fill14.occ", 32'(occ), 14);
    beat("ovf.b1", 8'h60, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    beat("ovf.b2", 8'h61, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    beat("ovf.b3", 8'h62, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    beat("ovf.b4", 8'h63, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    beat("ovf.b5", 8'h64, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    beat("ovf.b6", 8'h65, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_drop++; exp_ovf = 1'b1;
    chk("ovf.occ", 32'(occ), 14);
    chk_stats("ovf");
    drain("ovf", 14);

    // fill to 15 (almost full), packet discarded whole, accepted after drain
    for (int unsigned k = 0; k < 5; k++) good_pkt("fill15", 8'h70 + 8'(3 * k), 3);
    chk("fill15.occ", 32'(occ), 15);
    beat("af.b1", 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    beat("af.b2", 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    beat("af.b3", 8'h82, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_drop++;
    chk("af.occ", 32'(occ), 15);
    chk_stats("af");
    drain("af", 15);
    good_pkt("af.after", 8'h90, 2);
    chk_stats("af.after");
    drain("af.after", 2);

    // reset during beat 2 of a packet
    beat("rmid.b1", 8'hB0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    s_axis_tdata = 8'hB1; s_axis_tvalid = 1'b1; reset = 1'b1;
    #4;
    chk("rmid.wr", 32'(fifo_write), 0);
    chk("rmid.latch", 32'(latch_addr), 0);
    chk("rmid.drop", 32'(drop_pckt), 0);
    @(posedge clk); #1;
    reset = 1'b0; s_axis_tvalid = 1'b0;
    exp_good = 0; exp_drop = 0; exp_ovf = 1'b0;
    exp_q.delete();
    #4;
    chk("rmid.post.wr", 32'(fifo_write), 0);
    chk_stats("rmid.post");
    @(posedge clk); #1;
    good_pkt("rmid.fresh", 8'hC0, 1);
    chk_stats("rmid.fresh");
    drain("rmid.fresh", 1);
    chk("end.sbempty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
